// File: rtl/jesd204_rx_release_pkg.sv
// Shared state encoding for the JESD204 RX elastic buffer release controller.
package jesd204_rx_release_pkg;

  localparam int STATE_W = 3;

  typedef enum logic [STATE_W-1:0] {
    ST_IDLE       = 3'd0,
    ST_WAIT_READY = 3'd1,
    ST_WAIT_LMFC  = 3'd2,
    ST_DELAY      = 3'd3,
    ST_RELEASED   = 3'd4
  } rel_state_e;

endpackage

// File: rtl/elastic_buffer_release_ctrl.sv
// Releases all RX elastic buffers together once every enabled lane is writing,
// aligned to LMFC plus a programmable delay. Optional ELASTIC_BUFFER_LATENCY_STATUS_EN.
//
// state       | meaning
// ------------+-------------------------------------------------------
// IDLE        | link disabled, buffers held
// WAIT_READY  | waiting for every enabled lane to report ready
// WAIT_LMFC   | all lanes ready, waiting for the next LMFC edge
// DELAY       | counting down cfg_buffer_delay cycles after LMFC
// RELEASED    | buffers reading; watching for lane loss
module elastic_buffer_release_ctrl
  import jesd204_rx_release_pkg::*;
#(
  parameter int NUM_LANES   = 4,
  parameter int DELAY_WIDTH = 8,
  parameter int LAT_WIDTH   = 12
) (
  input  logic                   clk,
  input  logic                   resetn,
  input  logic                   link_en,
  input  logic [NUM_LANES-1:0]   cfg_lanes_disable,
  input  logic [DELAY_WIDTH-1:0] cfg_buffer_delay,
  input  logic                   cfg_buffer_early_release,
  input  logic                   lmfc_edge,
  input  logic [NUM_LANES-1:0]   lane_ready_n,
  input  logic                   clr_status,
  output logic                   do_release_n,
  output logic [STATE_W-1:0]     status_state,
  output logic [NUM_LANES-1:0]   status_lane_lost,
  output logic [LAT_WIDTH-1:0]   status_latency
);

  rel_state_e             state_q, state_d;
  logic [DELAY_WIDTH-1:0] cnt_q, cnt_d;
  logic                   do_release_n_q;
  logic [NUM_LANES-1:0]   lost_q;
  logic [NUM_LANES-1:0]   lost_evt;
  logic                   lanes_ready;

  // A fully disabled lane set must never count as ready.
  assign lanes_ready = (&(~lane_ready_n | cfg_lanes_disable)) & ~(&cfg_lanes_disable);
  assign lost_evt    = (state_q == ST_RELEASED && link_en) ? (lane_ready_n & ~cfg_lanes_disable)
                                                           : '0;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!link_en) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_WAIT_READY;
        ST_WAIT_READY: begin
          if (lanes_ready) state_d = cfg_buffer_early_release ? ST_RELEASED : ST_WAIT_LMFC;
        end
        ST_WAIT_LMFC: begin
          if (!lanes_ready) begin
            state_d = ST_WAIT_READY;
          end else if (lmfc_edge) begin
            if (cfg_buffer_delay == '0) begin
              state_d = ST_RELEASED;
            end else begin
              state_d = ST_DELAY;
              cnt_d   = cfg_buffer_delay;
            end
          end
        end
        ST_DELAY: begin
          if (!lanes_ready) begin
            state_d = ST_WAIT_READY;
            cnt_d   = '0;
          end else begin
            cnt_d = (cnt_q != '0) ? cnt_q - DELAY_WIDTH'(1) : '0;
            if (cnt_q <= DELAY_WIDTH'(1)) state_d = ST_RELEASED;
          end
        end
        ST_RELEASED: begin
          if (|lost_evt) state_d = ST_WAIT_READY;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Release lags entry to RELEASED by one edge; leaving RELEASED re-holds at once.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q        <= ST_IDLE;
      cnt_q          <= '0;
      do_release_n_q <= 1'b1;
      lost_q         <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      do_release_n_q <= !(state_q == ST_RELEASED && state_d == ST_RELEASED);
      lost_q         <= (clr_status ? '0 : lost_q) | lost_evt;
    end
  end

  assign do_release_n     = do_release_n_q;
  assign status_state     = state_q;
  assign status_lane_lost = lost_q;

`ifdef ELASTIC_BUFFER_LATENCY_STATUS_EN
  logic [LAT_WIDTH-1:0] lat_cnt_q, lat_cnt_d, lat_q;

  function automatic logic [LAT_WIDTH-1:0] sat_inc(input logic [LAT_WIDTH-1:0] v);
    return (&v) ? v : v + LAT_WIDTH'(1);
  endfunction

  always_comb begin
    lat_cnt_d = lat_cnt_q;
    if (state_d == ST_WAIT_LMFC && state_q != ST_WAIT_LMFC) begin
      lat_cnt_d = '0;
    end else if (state_q == ST_WAIT_LMFC || state_q == ST_DELAY) begin
      lat_cnt_d = sat_inc(lat_cnt_q);
    end
  end

  // The +1 accounts for the edge between entering RELEASED and do_release_n falling.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      lat_cnt_q <= '0;
      lat_q     <= '0;
    end else begin
      lat_cnt_q <= lat_cnt_d;
      if (state_d == ST_RELEASED && state_q != ST_RELEASED) begin
        lat_q <= (state_q == ST_WAIT_READY) ? LAT_WIDTH'(1) : sat_inc(lat_cnt_d);
      end else if (clr_status) begin
        lat_q <= '0;
      end
    end
  end

  assign status_latency = lat_q;
`else
  assign status_latency = '0;
`endif

endmodule
